fetch_unit: RTL and testbench

- Instruction fetch stage for the MIPS pipeline; produces the op/func fields and other instruction fields consumed by the control decoder and register file.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Presents one instruction at a time to decode with a valid/stall handshake.
- Redirects on jump (including JR) and flushes wrong-path instructions.

---
 rtl/fetch_unit_if.sv | 45 ++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Groups the instruction-memory request bus and the decode-side
//   handshake of the fetch stage into one bundle.
//
//   master : the fetch unit (drives imem_req/imem_addr and the if_* outputs)
//   slave  : the environment (instruction memory, decode, jump control)
//
//   imem_req/imem_addr/imem_ack/imem_rdata : single-outstanding fetch bus
//   stall                                 : decode cannot accept
//   jump_en/jump_target                   : redirect pulse and address
//   if_valid/if_instr/if_pc               : instruction presented to decode
//   op/rs/rt/rd/shamt/func/imm            : field slices of if_instr
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_target;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        func;
  logic [15:0]       imm;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
           op, rs, rt, rd, shamt, func, imm,
    input  imem_ack, imem_rdata, stall, jump_en, jump_target
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
           op, rs, rt, rd, shamt, func, imm,
    output imem_ack, imem_rdata, stall, jump_en, jump_target
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   MIPS instruction fetch stage. Holds the PC, issues one request at a
//   time to instruction memory, presents one instruction to decode with a
//   valid/stall handshake and redirects/flushes on jump.
//
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : fetch_unit_if.master (memory bus, decode handshake, jump input,
//           instruction word, its address and decoded field slices)
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    SKID  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addr;
  logic              r_req;
  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [31:0]       r_skid_instr;
  logic [ADDR_W-1:0] r_skid_pc;

  logic              w_slot_free;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;

  // The output slot can take a new word if it is empty or being consumed.
  assign w_slot_free = !r_valid || !bus.stall;
  assign w_target    = {bus.jump_target[ADDR_W-1:2], 2'b00};
  // In REQ the PC and the request address are equal, so the increment
  // serves both the next PC and the next request address (wraps silently).
  assign w_pc_inc    = r_pc + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= START;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_req        <= 1'b0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_if_pc      <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      case (r_state)
        START: begin
          r_state <= REQ;
          r_req   <= 1'b1;
          if (bus.jump_en) begin
            r_pc   <= w_target;
            r_addr <= w_target;
          end else begin
            r_addr <= r_pc;
          end
        end

        REQ: begin
          if (bus.jump_en) begin
            // Flush the slot; an in-flight word is either dropped now (ack
            // this cycle) or drained so the bus protocol stays intact.
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= w_target;
            if (bus.imem_ack) begin
              r_addr <= w_target;
            end else begin
              r_state <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            r_pc <= w_pc_inc;
            if (w_slot_free) begin
              r_valid <= 1'b1;
              r_instr <= bus.imem_rdata;
              r_if_pc <= r_addr;
              r_addr  <= w_pc_inc;
            end else begin
              // Decode is stalled on a valid word: park the new one.
              r_skid_instr <= bus.imem_rdata;
              r_skid_pc    <= r_addr;
              r_req        <= 1'b0;
              r_state      <= SKID;
            end
          end else if (!bus.stall) begin
            r_valid <= 1'b0;
            r_instr <= '0;
          end
        end

        SKID: begin
          if (bus.jump_en) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= w_target;
            r_addr  <= w_target;
            r_req   <= 1'b1;
            r_state <= REQ;
          end else if (!bus.stall) begin
            r_valid <= 1'b1;
            r_instr <= r_skid_instr;
            r_if_pc <= r_skid_pc;
            r_addr  <= r_pc;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end

        DRAIN: begin
          // Old address stays on the bus until its ack; the word is dropped.
          // Later jumps only retarget the PC, so the last one wins.
          if (bus.jump_en) begin
            r_pc <= w_target;
          end
          if (bus.imem_ack) begin
            r_addr  <= bus.jump_en ? w_target : r_pc;
            r_state <= REQ;
          end
        end

        default: begin
          r_state <= START;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.if_valid  = r_valid;
  // r_instr is cleared whenever the slot empties, so fields read 0 then.
  assign bus.if_instr  = r_instr;
  assign bus.if_pc     = r_if_pc;
  assign bus.op        = r_instr[31:26];
  assign bus.rs        = r_instr[25:21];
  assign bus.rt        = r_instr[20:16];
  assign bus.rd        = r_instr[15:11];
  assign bus.shamt     = r_instr[10:6];
  assign bus.func      = r_instr[5:0];
  assign bus.imm       = r_instr[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives fetch_unit with a memory responder of configurable latency,
//   stall/jump/reset stimulus, and compares every cycle against a
//   queue-based model of the fetch stage. A second instance with an
//   8-bit address space exercises PC wrap-around.
module tb_fetch_unit;

  logic clk;
  logic rst_r;
  logic rst8_r;

  fetch_unit_if #(.ADDR_W(32)) bus ();
  fetch_unit_if #(.ADDR_W(8))  b8 ();

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (rst_r),
    .bus   (bus)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hF0)) dut8 (
    .clk   (clk),
    .reset (rst8_r),
    .bus   (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } fetch_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus controls
  bit          t_reset, t_stall, t_jump;
  logic [31:0] t_target;
  int          lat_fixed = 0;
  int          mem_wait  = 0;
  bit          spur_en   = 0;
  bit          force_ack = 0;
  bit          p8_follow = 1;
  int          mem_mode  = 0;

  // model state: what the fetch stage must be showing
  bit          m_known = 0;
  bit          m_start, m_req, m_drain, m_valid;
  logic [31:0] m_pc, m_addr, m_instr, m_ipc;
  fetch_t      m_skid[$];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (mem_mode == 0) return (a == 32'hC) ? 32'h00A41020 : a;
    return {a[15:0], 16'h0} ^ (a * 32'h9E3779B1);
  endfunction

  function automatic int next_lat();
    if (lat_fixed >= 0) return lat_fixed;
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    check("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) check("imem_addr", bus.imem_addr, m_addr);
    check("if_valid", 32'(bus.if_valid), 32'(m_valid));
    check("if_instr", bus.if_instr, m_instr);
    if (m_valid) check("if_pc", bus.if_pc, m_ipc);
    check("op",    32'(bus.op),    32'(m_instr[31:26]));
    check("rs",    32'(bus.rs),    32'(m_instr[25:21]));
    check("rt",    32'(bus.rt),    32'(m_instr[20:16]));
    check("rd",    32'(bus.rd),    32'(m_instr[15:11]));
    check("shamt", 32'(bus.shamt), 32'(m_instr[10:6]));
    check("func",  32'(bus.func),  32'(m_instr[5:0]));
    check("imm",   32'(bus.imm),   32'(m_instr[15:0]));
  endtask

  // One clock of the fetch stage as seen from outside: which word is on
  // the output, what is waiting behind it, and what address is requested.
  task automatic model_step(bit rst, bit ack, bit stl, bit jmp, logic [31:0] tgt);
    logic [31:0] t;
    bit          free;
    fetch_t      f;
    t    = {tgt[31:2], 2'b00};
    free = !m_valid || !stl;
    if (rst) begin
      m_known = 1; m_start = 1; m_req = 0; m_drain = 0; m_valid = 0;
      m_pc = 0; m_addr = 0; m_instr = 0; m_ipc = 0;
      m_skid.delete();
      return;
    end
    if (!m_known) return;
    if (m_start) begin
      m_start = 0;
      m_req   = 1;
      if (jmp) m_pc = t;
      m_addr = m_pc;
    end else if (m_skid.size() != 0) begin
      if (jmp) begin
        m_skid.delete();
        m_valid = 0; m_instr = 0;
        m_pc = t; m_addr = t; m_req = 1;
      end else if (!stl) begin
        f = m_skid.pop_front();
        m_valid = 1; m_instr = f.w; m_ipc = f.a;
        m_addr = m_pc; m_req = 1;
      end
    end else if (m_drain) begin
      if (jmp) m_pc = t;
      if (ack) begin
        m_drain = 0;
        m_addr  = m_pc;
      end
    end else begin
      if (jmp) begin
        m_valid = 0; m_instr = 0; m_pc = t;
        if (ack) m_addr = t;
        else     m_drain = 1;
      end else if (ack) begin
        f.w  = mem_word(m_addr);
        f.a  = m_addr;
        m_pc = m_addr + 32'd4;
        if (free) begin
          m_valid = 1; m_instr = f.w; m_ipc = f.a;
          m_addr = m_pc;
        end else begin
          m_skid.push_back(f);
          m_req = 0;
        end
      end else if (!stl) begin
        m_valid = 0; m_instr = 0;
      end
    end
  endtask

  // Called at the falling edge: check, drive inputs, advance the model.
  task automatic tick();
    logic        ack;
    logic [31:0] rdv;
    if (m_known) compare_all();
    ack = 1'b0;
    rdv = $urandom;
    if (t_reset) begin
      mem_wait = next_lat();
      ack = force_ack;
    end else if (m_req) begin
      if (mem_wait == 0) begin
        ack = 1'b1;
        rdv = mem_word(bus.imem_addr);
        mem_wait = next_lat();
      end else begin
        mem_wait--;
      end
    end else if (force_ack || (spur_en && $urandom_range(0, 3) == 0)) begin
      ack = 1'b1;
    end
    rst_r           = t_reset;
    bus.stall       = t_stall;
    bus.jump_en     = t_jump;
    bus.jump_target = t_target;
    bus.imem_ack    = ack;
    bus.imem_rdata  = rdv;
    rst8_r          = p8_follow ? t_reset : 1'b0;
    b8.imem_ack     = b8.imem_req;
    b8.imem_rdata   = {24'h0, b8.imem_addr};
    if (bus.if_valid && !t_stall && !t_reset)
      $display("xfer cyc=%0d pc=%h instr=%h", cyc, bus.if_pc, bus.if_instr);
    model_step(t_reset, ack, t_stall, t_jump, t_target);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    t_reset = 1; tick();
    t_reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc[$];
    int n;
    logic [31:0] frozen;
    rst_r = 1; rst8_r = 1;
    bus.stall = 0; bus.jump_en = 0; bus.jump_target = 0;
    bus.imem_ack = 0; bus.imem_rdata = 0;
    b8.stall = 0; b8.jump_en = 0; b8.jump_target = 0;
    b8.imem_ack = 0; b8.imem_rdata = 0;
    t_reset = 1; t_stall = 0; t_jump = 0; t_target = 0;
    @(negedge clk);

    // zero-wait memory, word = address; reset state and back-to-back fetch
    lat_fixed = 0; mem_mode = 0;
    tick(); tick();
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_valid", 32'(bus.if_valid), 32'h0);
    check("rst_instr", bus.if_instr, 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    t_reset = 0; tick();
    check("start_req", 32'(bus.imem_req), 32'h1);
    tick();
    check("seq0", bus.if_instr, 32'h0);
    check("seq0_valid", 32'(bus.if_valid), 32'h1);
    check("w8_pc0", 32'(b8.if_pc), 32'hF0);
    tick(); check("seq1", bus.if_instr, 32'h4);
    tick(); check("seq2", bus.if_instr, 32'h8);
    tick();
    check("dec_instr", bus.if_instr, 32'h00A41020);
    check("dec_op", 32'(bus.op), 32'h0);
    check("dec_func", 32'(bus.func), 32'h20);
    check("dec_rs", 32'(bus.rs), 32'h5);
    check("dec_rt", 32'(bus.rt), 32'h4);
    check("dec_rd", 32'(bus.rd), 32'h2);
    check("w8_pc_fc", 32'(b8.if_pc), 32'hFC);
    check("w8_addr_wrap", 32'(b8.imem_addr), 32'h00);
    tick();
    check("w8_pc_wrap", 32'(b8.if_pc), 32'h00);
    p8_follow = 0;

    // 3 wait cycles: one instruction every 4 cycles
    lat_fixed = 3;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.if_valid) vc.push_back(cyc);
    end
    check("lat_nvalid", 32'(vc.size() >= 4), 32'h1);
    for (int i = 1; i < 4 && i < vc.size(); i++)
      check("lat_interval", 32'(vc[i] - vc[i-1]), 32'd4);

    // stall while the next ack lands: skid, then release
    lat_fixed = 0;
    do_reset();
    n = 0;
    while (!bus.if_valid && n < 10) begin tick(); n++; end
    frozen = bus.if_instr;
    check("stall_first", frozen, 32'h0);
    t_stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", bus.if_instr, frozen);
      check("stall_req", 32'(bus.imem_req), 32'h0);
    end
    t_stall = 0;
    tick(); check("skid_out", bus.if_instr, 32'h4);
    tick(); check("skid_next", bus.if_instr, 32'h8);

    // jump while the 0x20 request is pending, ack 2 cycles later
    do_reset();
    n = 0;
    while (!(bus.imem_req && bus.imem_addr == 32'h20) && n < 20) begin tick(); n++; end
    check("reach_0x20", bus.imem_addr, 32'h20);
    mem_wait = 2;
    t_jump = 1; t_target = 32'h103; tick();
    t_jump = 0;
    check("jmp_valid", 32'(bus.if_valid), 32'h0);
    check("jmp_hold_addr", bus.imem_addr, 32'h20);
    tick();
    tick();
    check("jmp_new_addr", bus.imem_addr, 32'h100);
    check("jmp_drop", 32'(bus.if_valid), 32'h0);
    tick();
    check("jmp_target_pc", bus.if_pc, 32'h100);

    // reset during a pending request; late ack ignored
    lat_fixed = 3;
    do_reset();
    tick(); tick();
    t_reset = 1; tick();
    check("rst_mid_req", 32'(bus.imem_req), 32'h0);
    t_reset = 0; force_ack = 1; tick(); force_ack = 0;
    check("rst_late_ack_valid", 32'(bus.if_valid), 32'h0);
    check("rst_refetch_addr", bus.imem_addr, 32'h0);
    n = 0;
    while (!bus.if_valid && n < 10) begin tick(); n++; end
    check("rst_first_pc", bus.if_pc, 32'h0);

    // randomized traffic
    lat_fixed = -1; spur_en = 1; mem_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      t_reset  = ($urandom_range(0, 199) == 0);
      t_stall  = ($urandom_range(0, 99) < 35);
      t_jump   = ($urandom_range(0, 99) < 6);
      t_target = $urandom;
      tick();
    end
    t_reset = 0; t_stall = 0; t_jump = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
